// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the memory-game datapath. The game
// controller, counter, comparator and pattern_sequencer all use it.
//   seq_state_t    : playback FSM states of pattern_sequencer
//   PATTERN_W      : width of a stored game pattern
//   SEQ_ON_CYCLES  : default cycles each pattern bit is displayed
//   SEQ_OFF_CYCLES : default blank cycles after each displayed bit
// -----------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    localparam int PATTERN_W      = 16;
    localparam int SEQ_ON_CYCLES  = 4;
    localparam int SEQ_OFF_CYCLES = 2;

    // The dwell timer only needs to hold max(on, off) - 1. When both dwell
    // times are 1 that value is 0, so keep at least one bit of storage.
    function automatic int timer_w(input int on_c, input int off_c);
        int m;
        m = (on_c > off_c) ? on_c : off_c;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// -----------------------------------------------------------------------------
// dwell_timer
// Loadable down-counter that measures both the ON and OFF dwell periods.
// The count holds at zero instead of wrapping; the owner reloads it.
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset, clears the count
//   clr_i      : clear the count (abort path)
//   load_i     : load load_val_i this cycle
//   load_val_i : value to load (dwell length - 1)
//   zero_o     : count is zero, i.e. the current dwell period ends this cycle
// -----------------------------------------------------------------------------
module dwell_timer #(
    parameter int TW = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    output logic          zero_o
);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pattern_sequencer.sv
// -----------------------------------------------------------------------------
// pattern_sequencer
// Plays a latched game pattern to the display one bit at a time, most
// significant shown bit first (pattern[length-1] down to pattern[0]), each
// bit shown for ON_CYCLES and followed by OFF_CYCLES of blank, then pulses
// done for one cycle.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   start      : begin playback (only honoured in IDLE)
//   abort      : cancel playback, back to IDLE without done
//   pattern    : pattern to play, latched on accepted start
//   length     : number of bits to play, clamped to WIDTH
//   busy       : sequencer is not IDLE
//   show_valid : a bit is being displayed
//   show_bit   : displayed bit value, 0 when show_valid is low
//   bit_idx    : pattern index of the bit in flight
//   done       : one-cycle completion pulse
// All outputs decode registered state only.
// -----------------------------------------------------------------------------
module pattern_sequencer
    import game_pkg::*;
#(
    parameter int WIDTH      = PATTERN_W,
    parameter int ON_CYCLES  = SEQ_ON_CYCLES,
    parameter int OFF_CYCLES = SEQ_OFF_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [WIDTH-1:0]           pattern,
    input  logic [$clog2(WIDTH+1)-1:0] length,
    output logic                       busy,
    output logic                       show_valid,
    output logic                       show_bit,
    output logic [$clog2(WIDTH)-1:0]   bit_idx,
    output logic                       done
);

    localparam int LW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);
    localparam int TW = timer_w(ON_CYCLES, OFF_CYCLES);

    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [IW-1:0]    idx_q, idx_d;

    logic          tmr_clr;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_zero;
    logic [LW-1:0] len_clamped;

    // Lengths beyond the register width play every stored bit once.
    assign len_clamped = (length > LW'(WIDTH)) ? LW'(WIDTH) : length;

    dwell_timer #(
        .TW(TW)
    ) u_dwell_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (tmr_clr),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        idx_d    = idx_q;
        tmr_clr  = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;

        if (abort) begin
            state_d = IDLE;
            idx_d   = '0;
            tmr_clr = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            state_d = DONE;
                            idx_d   = '0;
                        end else begin
                            pat_d    = pattern;
                            idx_d    = IW'(len_clamped - LW'(1));
                            state_d  = ON;
                            tmr_load = 1'b1;
                            tmr_val  = ON_LOAD;
                        end
                    end
                end
                ON: begin
                    if (tmr_zero) begin
                        state_d  = OFF;
                        tmr_load = 1'b1;
                        tmr_val  = OFF_LOAD;
                    end
                end
                OFF: begin
                    if (tmr_zero) begin
                        if (idx_q == '0) begin
                            state_d = DONE;
                        end else begin
                            idx_d    = idx_q - IW'(1);
                            state_d  = ON;
                            tmr_load = 1'b1;
                            tmr_val  = ON_LOAD;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign show_valid = (state_q == ON);
    assign show_bit   = (state_q == ON) ? pat_q[idx_q] : 1'b0;
    assign bit_idx    = idx_q;
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_pattern_sequencer.sv
module tb_pattern_sequencer;

    localparam int W    = 16;
    localparam int ONC  = 4;
    localparam int OFFC = 2;
    localparam int P    = ONC + OFFC;
    localparam int LW   = $clog2(W + 1);
    localparam int IW   = $clog2(W);

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [W-1:0]  pattern;
    logic [LW-1:0] length;
    logic          busy, show_valid, show_bit, done;
    logic [IW-1:0] bit_idx;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    pattern_sequencer #(
        .WIDTH      (W),
        .ON_CYCLES  (ONC),
        .OFF_CYCLES (OFFC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .pattern    (pattern),
        .length     (length),
        .busy       (busy),
        .show_valid (show_valid),
        .show_bit   (show_bit),
        .bit_idx    (bit_idx),
        .done       (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: a playback is described only by the cycle offset r
    // since the accepting start, the clamped length and the latched pattern.
    bit         m_known = 1'b0;
    bit         m_act   = 1'b0;
    int         m_r     = 0;
    int         m_len   = 0;
    logic [W-1:0] m_pat = '0;

    // Packed as {busy, show_valid, show_bit, bit_idx, done}.
    function automatic logic [IW+3:0] exp_out(input bit act, input int r, input int len,
                                              input logic [W-1:0] p);
        int  k, ph, idx;
        bit  sv, sb;
        if (!act) return '0;
        if (r == 1 + len * P) return {1'b1, 1'b0, 1'b0, IW'(0), 1'b1};
        k   = (r - 1) / P;
        ph  = (r - 1) % P;
        idx = len - 1 - k;
        sv  = (ph < ONC);
        sb  = sv ? p[idx] : 1'b0;
        return {1'b1, sv, sb, IW'(idx), 1'b0};
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_known = 1'b1;
            m_act   = 1'b0;
        end else if (abort) begin
            m_act = 1'b0;
        end else if (m_act) begin
            if (m_r == 1 + m_len * P) m_act = 1'b0;
            else m_r++;
        end else if (start) begin
            m_act = 1'b1;
            m_r   = 1;
            m_len = (int'(length) > W) ? W : int'(length);
            m_pat = pattern;
        end
    end

    always @(negedge clk) begin
        if (m_known)
            chk("outputs{busy,valid,bit,idx,done}",
                32'({busy, show_valid, show_bit, bit_idx, done}),
                32'(exp_out(m_act, m_r, m_len, m_pat)));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge (cycle 0); returns at the negedge of cycle 1.
    task automatic run_start(input logic [W-1:0] pat, input logic [LW-1:0] len);
        pattern = pat;
        length  = len;
        start   = 1'b1;
        tick(1);
        start   = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b1;
        abort   = 1'b0;
        pattern = 16'hFFFF;
        length  = 5'd5;
        tick(2);
        chk("reset_outputs", 32'({busy, show_valid, show_bit, bit_idx, done}), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick(1);
        chk("start_in_reset_ignored", 32'(busy), 32'd0);

        // Nominal playback with mid-play input changes and a second start.
        run_start(16'h0005, 5'd3);
        chk("nom_c1_valid", 32'(show_valid), 32'd1);
        chk("nom_c1_bit", 32'(show_bit), 32'd1);
        chk("nom_c1_idx", 32'(bit_idx), 32'd2);
        pattern = 16'hFFFA;
        length  = 5'd7;
        tick(4);                       // cycle 5
        pattern = 16'hAAAA;
        start   = 1'b1;
        tick(1);                       // cycle 6
        start   = 1'b0;
        chk("nom_c6_blank", 32'(show_valid), 32'd0);
        tick(1);                       // cycle 7
        chk("nom_c7_bit", 32'(show_bit), 32'd0);
        chk("nom_c7_idx", 32'(bit_idx), 32'd1);
        tick(6);                       // cycle 13
        chk("nom_c13_bit", 32'(show_bit), 32'd1);
        chk("nom_c13_idx", 32'(bit_idx), 32'd0);
        tick(5);                       // cycle 18
        chk("nom_c18_nodone", 32'(done), 32'd0);
        tick(1);                       // cycle 19
        chk("nom_c19_done", 32'(done), 32'd1);
        chk("nom_c19_busy", 32'(busy), 32'd1);
        tick(1);                       // cycle 20: idle, back-to-back start
        run_start(16'h0001, 5'd1);
        chk("b2b_accepted", 32'({show_valid, show_bit}), 32'd3);
        tick(8);

        // Zero length.
        run_start(16'hFFFF, 5'd0);
        chk("zero_c1_done", 32'(done), 32'd1);
        chk("zero_c1_busy", 32'(busy), 32'd1);
        chk("zero_c1_valid", 32'(show_valid), 32'd0);
        tick(1);
        chk("zero_c2_busy", 32'(busy), 32'd0);
        tick(2);

        // Over-length clamp.
        run_start(16'h8000, 5'd20);
        chk("clamp_first_bit", 32'(show_bit), 32'd1);
        chk("clamp_first_idx", 32'(bit_idx), 32'd15);
        tick(95);                      // cycle 96
        chk("clamp_c96_nodone", 32'(done), 32'd0);
        tick(1);                       // cycle 97
        chk("clamp_c97_done", 32'(done), 32'd1);
        tick(2);

        // Abort mid-play, then restart.
        run_start(16'h0005, 5'd3);
        tick(7);                       // cycle 8
        abort = 1'b1;
        tick(1);                       // cycle 9
        abort = 1'b0;
        chk("abort_idle", 32'({busy, done}), 32'd0);
        run_start(16'h0004, 5'd3);
        chk("restart_bit", 32'(show_bit), 32'd1);
        chk("restart_idx", 32'(bit_idx), 32'd2);
        tick(22);

        // Abort together with start in IDLE.
        abort = 1'b1;
        start = 1'b1;
        tick(1);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_beats_start", 32'(busy), 32'd0);

        // Randomized traffic, including occasional mid-play reset.
        for (int i = 0; i < 3000; i++) begin
            start   = ($urandom_range(0, 3) == 0);
            abort   = ($urandom_range(0, 59) == 0);
            rst     = ($urandom_range(0, 499) == 0);
            pattern = W'($urandom);
            length  = LW'($urandom_range(0, 20));
            tick(1);
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
        tick(120);
        chk("final_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_sequencer.md
# pattern_sequencer

Plays a stored game pattern back to the player one bit at a time with fixed on/off dwell times, then signals completion. Sits between the pattern generator and the display/LED driver. The game controller asserts `start` in the pattern phase and waits on `done` before enabling input capture. Bit order matches input capture: the first bit the player must enter is shown first.

## Interface
Parameters:
- `WIDTH`, 16: pattern register width.
- `ON_CYCLES`, 4: cycles each bit is displayed; must be ≥ 1.
- `OFF_CYCLES`, 2: blank cycles after each bit; must be ≥ 1.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin playback; sampled only in IDLE.
- `abort`  in  1  cancel playback; highest priority after `rst`.
- `pattern`  in  WIDTH  pattern to show; latched on accepted `start`.
- `length`  in  $clog2(WIDTH+1)  number of bits to show; latched on accepted `start`.
- `busy`  out  1  high in every state except IDLE.
- `show_valid`  out  1  high while a bit is displayed (ON state).
- `show_bit`  out  1  bit currently displayed; 0 when `show_valid` is low.
- `bit_idx`  out  $clog2(WIDTH)  index of the bit in flight.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, ON, OFF, DONE.
- **IDLE:**
  - `start` with `length` ≥ 1: latch pattern; clamp length to WIDTH; set idx = length−1; go to ON; load timer = ON_CYCLES−1.
  - `start` with `length` = 0: go to DONE; no bit is shown.
- **ON:**
  - `show_valid` = 1; `show_bit` = latched_pattern[idx].
  - When timer = 0: go to OFF; load timer = OFF_CYCLES−1.
  - Otherwise decrement timer.
- **OFF:**
  - All display outputs are 0.
  - When timer = 0 and idx = 0: go to DONE.
  - When timer = 0 and idx ≠ 0: decrement idx; go to ON; reload timer = ON_CYCLES−1.
  - Otherwise decrement timer.
- **DONE:** `done` = 1 for exactly one cycle; go to IDLE.
- Bits play from pattern[length−1] down to pattern[0].
- `start` outside IDLE is ignored. Input changes after latching have no effect.
- `abort` in any state: go to IDLE next cycle; no `done` pulse; idx and timer cleared.
- `abort` together with `start` in IDLE: `abort` wins; stay in IDLE.
- `rst` (any cycle, including mid-playback): state IDLE; all outputs 0; latched pattern, length, idx and timer cleared.

## Timing
- Outputs are registered-state decodes; no combinational path from inputs to outputs.
- `start` accepted in cycle 0:
  - First `show_valid` is in cycle 1.
  - Bit k (in playback order, k = 0..L−1) is shown in cycles 1+k·(ON+OFF) through k·(ON+OFF)+ON.
- `done` is high in cycle 1+L·(ON_CYCLES+OFF_CYCLES).
  - Example: ON = 4, OFF = 2, L = 3 gives `done` in cycle 19.
- L = 0: `done` in cycle 1; `busy` high in cycle 1 only.
- `busy` is high from cycle 1 through the `done` cycle inclusive.
- Back-to-back use: a `start` in the cycle after `done` (IDLE) is accepted.
- Timer width is $clog2(max(ON_CYCLES, OFF_CYCLES)). Timer and idx never wrap: they are reloaded before underflow.

## Structure
- Shared package `game_pkg` holds:
  - `seq_state_t` enum {IDLE, ON, OFF, DONE}.
  - Default timing constants `SEQ_ON_CYCLES` and `SEQ_OFF_CYCLES`.
  - `PATTERN_W` = 16, reused by the game controller, counter and comparator.
- One sub-module, `dwell_timer`: loadable down-counter with a `load` value and a `zero` flag, used for both ON and OFF dwell.
- Everything else (FSM, idx register, pattern latch) stays in `pattern_sequencer`.

## Test plan
- **Reset:** assert `rst` for 2 cycles → all outputs 0, state IDLE; `start` during `rst` is ignored.
- **Nominal playback:** pattern = 16'h0005, length = 3, ON = 4, OFF = 2.
  - `show_bit` sequence 1, 0, 1 on cycles 1–4, 7–10, 13–16.
  - `bit_idx` 2, 1, 0.
  - `done` in cycle 19 only.
- **Zero length:** length = 0 → no `show_valid`; `done` in cycle 1; `busy` high in cycle 1 only.
- **Over-length clamp:** length = 20 with WIDTH = 16 → exactly 16 bits shown, pattern[15] first; `done` in cycle 97.
- **Abort:** assert `abort` in cycle 8 of a 3-bit playback → IDLE in cycle 9; no `done`. A new `start` in cycle 9 replays from the top.
- **Start while busy and pattern stability:**
  - Second `start` with a different pattern in cycle 5 is ignored.
  - Changing `pattern`/`length` mid-play does not alter the output.
  - A `start` in the cycle after `done` is accepted.
